// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Package     : booth_pkg
// Description : Shared widths, Booth digit type and the radix-4 group decoder
//               used by the Booth partial-product generator.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

  localparam int OP_W   = 32;  // operand width
  localparam int PP_W   = 64;  // partial-product / product width
  localparam int NUM_PP = 17;  // Booth digits for a 32-bit operand plus extension

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // grp = {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_digit_t booth_decode(input logic [2:0] grp);
    booth_digit_t d;
    case (grp)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;  // 000, 111
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_pp_cell.sv
`default_nettype none
// ============================================================================
// Module      : booth_pp_cell
// Description : One radix-4 Booth partial product. Decodes a 3-bit group and
//               produces (digit * aext) << SHIFT as a complete 64-bit two's
//               complement word, so no correction bits are needed downstream.
// Ports       : aext_i  [63:0] extended multiplicand
//               grp_i   [2:0]  Booth group {b[2i+1], b[2i], b[2i-1]}
//               pp_o    [63:0] combinational partial product
// Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_cell
  import booth_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [PP_W-1:0] aext_i,
  input  logic [2:0]      grp_i,
  output logic [PP_W-1:0] pp_o
);

  booth_digit_t      w_digit;
  logic [PP_W-1:0]   w_mult;

  assign w_digit = booth_decode(grp_i);

  always_comb begin
    w_mult = '0;
    case (w_digit)
      POS1:    w_mult = aext_i;
      POS2:    w_mult = aext_i << 1;
      NEG1:    w_mult = -aext_i;
      NEG2:    w_mult = -(aext_i << 1);
      default: w_mult = '0;
    endcase
  end

  assign pp_o = w_mult << SHIFT;

endmodule
`default_nettype wire

// File: rtl/booth_radix4_pp_gen.sv
`default_nettype none
// ============================================================================
// Module      : booth_radix4_pp_gen
// Description : Radix-4 Booth partial-product generator for a 32x32 signed /
//               unsigned multiplier. Emits 17 registered, pre-shifted,
//               fully sign-extended 64-bit partial products whose mod-2^64
//               sum equals A*B. One-cycle latency, one operation per cycle.
// Ports       : clk         clock, rising edge
//               rst_n       synchronous active-low reset (clears all PPs)
//               A   [31:0]  multiplicand
//               B   [31:0]  multiplier (Booth-recoded)
//               alu_signed  1: two's complement operands, 0: unsigned
//               PP0..PP16   [63:0] registered partial products
// Revision    : 1.0 - initial release
// ============================================================================
module booth_radix4_pp_gen
  import booth_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] A,
  input  logic [OP_W-1:0] B,
  input  logic            alu_signed,
  output logic [PP_W-1:0] PP0,
  output logic [PP_W-1:0] PP1,
  output logic [PP_W-1:0] PP2,
  output logic [PP_W-1:0] PP3,
  output logic [PP_W-1:0] PP4,
  output logic [PP_W-1:0] PP5,
  output logic [PP_W-1:0] PP6,
  output logic [PP_W-1:0] PP7,
  output logic [PP_W-1:0] PP8,
  output logic [PP_W-1:0] PP9,
  output logic [PP_W-1:0] PP10,
  output logic [PP_W-1:0] PP11,
  output logic [PP_W-1:0] PP12,
  output logic [PP_W-1:0] PP13,
  output logic [PP_W-1:0] PP14,
  output logic [PP_W-1:0] PP15,
  output logic [PP_W-1:0] PP16
);

  localparam int BX_W = 2*NUM_PP + 1;  // 34-bit extended B plus implicit b[-1]

  logic                          w_sext_a;
  logic                          w_sext_b;
  logic [PP_W-1:0]               w_aext;
  logic [BX_W-1:0]               w_bx;     // w_bx[k+1] = Bext[k], w_bx[0] = b[-1] = 0
  logic [NUM_PP-1:0][PP_W-1:0]   pp_d;
  logic [NUM_PP-1:0][PP_W-1:0]   pp_q;

  assign w_sext_a = alu_signed & A[OP_W-1];
  assign w_sext_b = alu_signed & B[OP_W-1];
  assign w_aext   = {{(PP_W-OP_W){w_sext_a}}, A};
  assign w_bx     = {{(BX_W-1-OP_W){w_sext_b}}, B, 1'b0};

  generate
    for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
      booth_pp_cell #(
        .SHIFT (2*i)
      ) u_cell (
        .aext_i (w_aext),
        .grp_i  (w_bx[2*i+2 -: 3]),
        .pp_o   (pp_d[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pp_q <= '0;
    end else begin
      pp_q <= pp_d;
    end
  end

  assign PP0  = pp_q[0];
  assign PP1  = pp_q[1];
  assign PP2  = pp_q[2];
  assign PP3  = pp_q[3];
  assign PP4  = pp_q[4];
  assign PP5  = pp_q[5];
  assign PP6  = pp_q[6];
  assign PP7  = pp_q[7];
  assign PP8  = pp_q[8];
  assign PP9  = pp_q[9];
  assign PP10 = pp_q[10];
  assign PP11 = pp_q[11];
  assign PP12 = pp_q[12];
  assign PP13 = pp_q[13];
  assign PP14 = pp_q[14];
  assign PP15 = pp_q[15];
  assign PP16 = pp_q[16];

endmodule
`default_nettype wire

// File: tb/tb_booth_radix4_pp_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_radix4_pp_gen
// Description : Scoreboard bench for booth_radix4_pp_gen. Stimulus pushes the
//               expected sum (and optionally expected individual PPs) into a
//               queue; a monitor pops one entry per issued cycle and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_radix4_pp_gen;

  typedef struct {
    string              name;
    logic [63:0]        sum;
    logic [16:0]        mask;   // which PPs to compare individually
    logic [16:0][63:0]  pp;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  A = '0;
  logic [31:0]  B = '0;
  logic         alu_signed = 1'b0;
  logic [63:0]  pp_w [17];

  int   checks = 0;
  int   failures = 0;
  bit   issued = 1'b0;
  exp_t sb_q [$];

  always #5 clk = ~clk;

  booth_radix4_pp_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (A),
    .B          (B),
    .alu_signed (alu_signed),
    .PP0  (pp_w[0]),  .PP1  (pp_w[1]),  .PP2  (pp_w[2]),  .PP3  (pp_w[3]),
    .PP4  (pp_w[4]),  .PP5  (pp_w[5]),  .PP6  (pp_w[6]),  .PP7  (pp_w[7]),
    .PP8  (pp_w[8]),  .PP9  (pp_w[9]),  .PP10 (pp_w[10]), .PP11 (pp_w[11]),
    .PP12 (pp_w[12]), .PP13 (pp_w[13]), .PP14 (pp_w[14]), .PP15 (pp_w[15]),
    .PP16 (pp_w[16])
  );

  // ---------------- expectation builders ----------------
  function automatic exp_t mk(input string name, input logic [63:0] sum,
                              input logic [16:0] mask);
    exp_t e;
    e.name = name;
    e.sum  = sum;
    e.mask = mask;
    e.pp   = '0;
    return e;
  endfunction

  // Independent reference: plain 64-bit multiply of extended operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic rst_lvl, input exp_t e);
    @(negedge clk);
    A          = a;
    B          = b;
    alu_signed = s;
    rst_n      = rst_lvl;
    sb_q.push_back(e);
    issued     = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      if (issued) begin
        exp_t        e;
        logic [63:0] sum;
        #1;
        sum = '0;
        for (int i = 0; i < 17; i++) sum = sum + pp_w[i];
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow: output with no expectation queued");
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (sum !== e.sum) begin
            failures++;
            $display("FAIL %s sum: got %h expected %h", e.name, sum, e.sum);
          end
          for (int i = 0; i < 17; i++) begin
            if (e.mask[i]) begin
              checks++;
              if (pp_w[i] !== e.pp[i]) begin
                failures++;
                $display("FAIL %s PP%0d: got %h expected %h", e.name, i, pp_w[i], e.pp[i]);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t        e;
    logic [31:0] ra, rb;
    logic        rs;
    logic [16:0] all_pp;
    logic [16:0] pp16_only;
    all_pp    = '1;
    pp16_only = 17'h10000;

    // Reset held for two cycles with all-ones operands.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, mk("reset_c0", 64'd0, all_pp));
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, mk("reset_c1", 64'd0, all_pp));

    // Signed small negatives, PP16 must be zero.
    issue(-32'sd1,    -32'sd1,   1'b1, 1'b1, mk("s_m1_m1",     64'd1,      pp16_only));
    issue(-32'sd2,    -32'sd3,   1'b1, 1'b1, mk("s_m2_m3",     64'd6,      pp16_only));
    issue(-32'sd15,   -32'sd7,   1'b1, 1'b1, mk("s_m15_m7",    64'd105,    pp16_only));
    issue(-32'sd128,  -32'sd64,  1'b1, 1'b1, mk("s_m128_m64",  64'd8192,   pp16_only));
    issue(-32'sd1024, -32'sd256, 1'b1, 1'b1, mk("s_m1024_m256",64'd262144, pp16_only));

    // Signed mixed.
    issue(32'sd32768,   -32'sd2,    1'b1, 1'b1, mk("s_32768_m2",   -64'sd65536,       pp16_only));
    issue(32'sd100000,  -32'sd123,  1'b1, 1'b1, mk("s_1e5_m123",   -64'sd12300000,    pp16_only));
    issue(32'sd9999999, -32'sd1111, 1'b1, 1'b1, mk("s_9999999_m1111", -64'sd11109998889, pp16_only));
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, mk("s_min_m1",  64'h0000_0000_8000_0000, pp16_only));

    // Per-PP encoding: A=5, B=2 -> PP0=-10, PP1=+20, rest zero.
    e = mk("pp_enc_5x2", 64'd10, all_pp);
    e.pp[0] = 64'hFFFF_FFFF_FFFF_FFF6;
    e.pp[1] = 64'd20;
    issue(32'd5, 32'd2, 1'b1, 1'b1, e);

    // Unsigned max operands, then same operands signed.
    e = mk("u_max_max", 64'hFFFF_FFFE_0000_0001, pp16_only);
    e.pp[16] = 64'hFFFF_FFFF_0000_0000;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, e);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, mk("s_max_max", 64'd1, pp16_only));

    // Reset arriving with a live operation discards it.
    issue(32'd7, 32'd9, 1'b0, 1'b0, mk("reset_inflight", 64'd0, all_pp));
    issue(32'd7, 32'd9, 1'b0, 1'b1, mk("after_reset", 64'd63, '0));

    // Back-to-back random operations, mode toggling freely.
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs, 1'b1, mk("rand", ref_prod(ra, rb, rs), '0));
    end

    @(negedge clk);
    issued = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
